uart_cmd_sequencer: RTL and testbench
=====================================

Name: uart_cmd_sequencer

Overview:
- Sits between the UART receiver and the audio/control blocks.
- Consumes the receiver's byte stream and frames it into commands: SYNC, CMD, LEN, payload, XOR checksum.
- Buffers the payload and presents each validated command to one downstream consumer over a valid/ready handshake.
- Aborts malformed, parity-failed or stalled frames and reports why.

Parameters:
- MAX_LEN, 16: maximum payload bytes per frame; payload buffer depth.
- TIMEOUT_CYCLES, 250000: idle CLK50MHz cycles allowed between bytes inside a frame (~4 byte times at 9600 baud).
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- CLK50MHz  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- RX_VALID  in  1  one-cycle strobe: RX_DATA holds a new received byte
- RX_DATA  in  8  received byte
- RX_PERR  in  1  parity error for the byte strobed by RX_VALID
- CMD_VALID  out  1  validated command available
- CMD_READY  in  1  consumer accepts the command
- CMD_OP  out  8  command opcode
- CMD_LEN  out  clog2(MAX_LEN+1)  payload length
- PAY_ADDR  in  clog2(MAX_LEN)  payload read address
- PAY_DATA  out  8  payload byte at PAY_ADDR, registered, 1-cycle latency
- FRAME_ERR  out  1  one-cycle pulse: frame aborted
- ERR_CODE  out  3  cause of last abort: 1 checksum, 2 bad length, 3 timeout, 4 parity; held until next abort
- OVERRUN  out  1  one-cycle pulse: byte dropped while holding a command

Behaviour:
- Clock and reset: CLK50MHz is the only clock. RESET is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, timeout counter 0, running checksum 0. RESET mid-frame discards the frame with no FRAME_ERR.
- Byte acceptance: a byte is accepted in any cycle with RX_VALID=1.
- States:
  - IDLE: byte == SYNC_BYTE and RX_PERR=0 -> CMD. Any other byte, or a parity-failed byte, is silently discarded.
  - CMD: latch opcode; chk <= byte; -> LEN.
  - LEN: byte > MAX_LEN -> abort, code 2. Otherwise latch length; chk ^= byte; byte==0 -> CHECK, else -> PAYLOAD with index 0.
  - PAYLOAD: write byte to buffer[index]; chk ^= byte; index++. After LEN bytes -> CHECK.
  - CHECK: byte == chk -> HOLD, with CMD_VALID=1 from the next cycle. Mismatch -> abort, code 1.
  - HOLD: CMD_VALID, CMD_OP and CMD_LEN are stable. CMD_VALID&CMD_READY -> IDLE next cycle, CMD_VALID low next cycle. RX_VALID in HOLD: byte dropped, OVERRUN pulses the next cycle. A byte arriving in the same cycle as the handshake is also dropped.
- Parity: RX_PERR=1 with RX_VALID in CMD/LEN/PAYLOAD/CHECK -> abort, code 4.
- Timeout: counter clears on each accepted byte and counts in CMD..CHECK. Reaching TIMEOUT_CYCLES-1 with no byte -> abort, code 3. If a byte arrives in the same cycle the limit is reached, the byte wins and no timeout occurs.
- Abort: FRAME_ERR pulses the cycle after detection, ERR_CODE updates in the same cycle, state -> IDLE. The aborting byte is not re-examined as SYNC.
- Payload read: PAY_DATA reflects buffer[PAY_ADDR] one cycle later. Contents are valid only while CMD_VALID=1. PAY_ADDR >= CMD_LEN returns don't-care.
- Buffer ownership: the buffer is written only in PAYLOAD, so it is never overwritten while CMD_VALID=1.
- Arithmetic: checksum is 8-bit XOR. Index and counter wrap is impossible by construction; the counter saturates at its limit.

Optional Feature:
- Macro: UART_CMD_STATS_EN.
- Defined: adds outputs FRAMES_OK[15:0], FRAMES_BAD[15:0] and DROPPED[15:0].
  - FRAMES_OK increments on each handshake.
  - FRAMES_BAD increments on each FRAME_ERR.
  - DROPPED increments on each OVERRUN.
  - All three saturate at 16'hFFFF, clear on RESET, and add no latency to the main path.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package uart_cmd_pkg holds:
  - state enum (IDLE, CMD, LEN, PAYLOAD, CHECK, HOLD)
  - ERR_NONE/ERR_CHKSUM/ERR_LEN/ERR_TIMEOUT/ERR_PARITY codes
  - default SYNC_BYTE constant
- One sub-module, uart_cmd_buf: MAX_LEN x 8 single-write, single-read register file with registered read.

Test Plan:
- Good frame: send A5 10 02 33 44 65 -> CMD_VALID=1, CMD_OP=10, CMD_LEN=2; PAY_ADDR 0/1 -> PAY_DATA 33/44. Assert CMD_READY -> CMD_VALID=0 next cycle, FRAME_ERR never set.
- Bad checksum: send A5 10 02 33 44 66 -> FRAME_ERR pulse, ERR_CODE=1, no CMD_VALID. A following good frame is accepted normally.
- Bad length (MAX_LEN=16): send A5 20 11 -> FRAME_ERR, ERR_CODE=2 after the LEN byte. Zero-length frame A5 07 00 07 -> CMD_VALID, CMD_LEN=0.
- Timeout (TIMEOUT_CYCLES=100): send A5 10, then 100 idle cycles -> FRAME_ERR, ERR_CODE=3. Repeat with a byte landing exactly on cycle 99 -> no abort.
- Parity and noise: send 00 FF, then A5 with RX_PERR=1 -> no action. Send A5 10 with RX_PERR=1 on 10 -> FRAME_ERR, ERR_CODE=4.
- Hold and overrun: complete a good frame, keep CMD_READY=0, send byte 55 -> OVERRUN pulse and CMD_OP/payload unchanged. Assert RESET during PAYLOAD -> all outputs 0 and no FRAME_ERR.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
// The top module's optional statistics outputs are enabled with UART_CMD_STATS_EN.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_HOLD
    } state_e;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CHKSUM  = 3'd1;
    localparam logic [2:0] ERR_LEN     = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_PARITY  = 3'd4;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload register file: one write port, one read port with a registered read.
// The read register clears on reset; the storage array itself does not.
module uart_cmd_buf #(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem_q [2**ADDR_W];
    logic [7:0] rd_data_q;
    logic [7:0] rd_data_d;

    always_comb begin
        rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
    end

    // NOTE: storage carries no reset; contents are only meaningful after being written.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Frames the UART byte stream (SYNC, CMD, LEN, payload, XOR checksum) into validated commands.
// Defining UART_CMD_STATS_EN adds saturating FRAMES_OK / FRAMES_BAD / DROPPED counters.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter  int         MAX_LEN        = 16,
    parameter  int         TIMEOUT_CYCLES = 250000,
    parameter  logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    localparam int         LEN_W          = $clog2(MAX_LEN + 1),
    localparam int         ADDR_W         = $clog2(MAX_LEN)
) (
    input  logic              CLK50MHz,
    input  logic              RESET,
    input  logic              RX_VALID,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_PERR,
    output logic              CMD_VALID,
    input  logic              CMD_READY,
    output logic [7:0]        CMD_OP,
    output logic [LEN_W-1:0]  CMD_LEN,
    input  logic [ADDR_W-1:0] PAY_ADDR,
    output logic [7:0]        PAY_DATA,
    output logic              FRAME_ERR,
    output logic [2:0]        ERR_CODE,
`ifdef UART_CMD_STATS_EN
    output logic [15:0]       FRAMES_OK,
    output logic [15:0]       FRAMES_BAD,
    output logic [15:0]       DROPPED,
`endif
    output logic              OVERRUN
);

    localparam int         CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e              state_q, state_d;
    logic [7:0]          op_q, op_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [7:0]          chk_q, chk_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          err_code_q, err_code_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q, overrun_d;
    logic                wr_en;
    logic                abort;
    logic [2:0]          abort_code;
    logic                in_frame;
    logic                byte_ok;
    logic                handshake;

    assign in_frame  = state_q inside {ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHECK};
    assign byte_ok   = RX_VALID && !RX_PERR;
    assign handshake = (state_q == ST_HOLD) && CMD_READY;

    always_comb begin
        // NOTE: every signal is given a default first so no path through the case infers a latch.
        state_d     = state_q;
        op_d        = op_q;
        len_d       = len_q;
        idx_d       = idx_q;
        chk_d       = chk_q;
        cnt_d       = cnt_q;
        err_code_d  = err_code_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        wr_en       = 1'b0;
        abort       = 1'b0;
        abort_code  = ERR_NONE;

        // Inter-byte timer: an arriving byte always beats the limit.
        if (in_frame) begin
            if (RX_VALID) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LIMIT) begin
                abort      = 1'b1;
                abort_code = ERR_TIMEOUT;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (RX_VALID && RX_PERR) begin
                abort      = 1'b1;
                abort_code = ERR_PARITY;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (byte_ok && RX_DATA == SYNC_BYTE) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (byte_ok) begin
                    op_d    = RX_DATA;
                    chk_d   = RX_DATA;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (byte_ok) begin
                    if (RX_DATA > MAX_LEN_B) begin
                        abort      = 1'b1;
                        abort_code = ERR_LEN;
                    end else begin
                        len_d   = RX_DATA[LEN_W-1:0];
                        chk_d   = chk_q ^ RX_DATA;
                        idx_d   = '0;
                        state_d = (RX_DATA == 8'd0) ? ST_CHECK : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_ok) begin
                    wr_en = 1'b1;
                    chk_d = chk_q ^ RX_DATA;
                    idx_d = idx_q + ADDR_W'(1);
                    if (LEN_W'(idx_q) + LEN_W'(1) == len_q) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (byte_ok) begin
                    if (RX_DATA == chk_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        abort      = 1'b1;
                        abort_code = ERR_CHKSUM;
                    end
                end
            end
            ST_HOLD: begin
                overrun_d = RX_VALID;
                if (CMD_READY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = abort_code;
            cnt_d       = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK50MHz) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            chk_q       <= '0;
            cnt_q       <= '0;
            err_code_q  <= ERR_NONE;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            chk_q       <= chk_d;
            cnt_q       <= cnt_d;
            err_code_q  <= err_code_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_cmd_buf #(.DEPTH(MAX_LEN)) u_buf (
        .clk     (CLK50MHz),
        .rst     (RESET),
        .wr_en   (wr_en),
        .wr_addr (idx_q),
        .wr_data (RX_DATA),
        .rd_addr (PAY_ADDR),
        .rd_data (PAY_DATA)
    );

    assign CMD_VALID = (state_q == ST_HOLD);
    assign CMD_OP    = op_q;
    assign CMD_LEN   = len_q;
    assign FRAME_ERR = frame_err_q;
    assign ERR_CODE  = err_code_q;
    assign OVERRUN   = overrun_q;

`ifdef UART_CMD_STATS_EN
    logic [15:0] ok_q, ok_d, bad_q, bad_d, drop_q, drop_d;

    // Counters advance alongside the events they count, so they never delay the main path.
    always_comb begin
        ok_d   = ok_q;
        bad_d  = bad_q;
        drop_d = drop_q;
        if (handshake   && ok_q   != 16'hFFFF) ok_d   = ok_q   + 16'd1;
        if (frame_err_d && bad_q  != 16'hFFFF) bad_d  = bad_q  + 16'd1;
        if (overrun_d   && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge CLK50MHz) begin
        if (RESET) begin
            ok_q   <= '0;
            bad_q  <= '0;
            drop_q <= '0;
        end else begin
            ok_q   <= ok_d;
            bad_q  <= bad_d;
            drop_q <= drop_d;
        end
    end

    assign FRAMES_OK  = ok_q;
    assign FRAMES_BAD = bad_q;
    assign DROPPED    = drop_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer with a frame-level reference model checked every cycle.
module tb_uart_cmd_sequencer;

    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 100;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_perr;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_op;
    logic [4:0] cmd_len;
    logic [3:0] pay_addr;
    logic [7:0] pay_data;
    logic       frame_err;
    logic [2:0] err_code;
    logic       overrun;
`ifdef UART_CMD_STATS_EN
    logic [15:0] frames_ok, frames_bad, dropped;
`endif

    uart_cmd_sequencer #(
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .CLK50MHz  (clk),
        .RESET     (rst),
        .RX_VALID  (rx_valid),
        .RX_DATA   (rx_data),
        .RX_PERR   (rx_perr),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD_OP    (cmd_op),
        .CMD_LEN   (cmd_len),
        .PAY_ADDR  (pay_addr),
        .PAY_DATA  (pay_data),
        .FRAME_ERR (frame_err),
        .ERR_CODE  (err_code),
`ifdef UART_CMD_STATS_EN
        .FRAMES_OK (frames_ok),
        .FRAMES_BAD(frames_bad),
        .DROPPED   (dropped),
`endif
        .OVERRUN   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Frame-level model: gathers frame bytes into a queue and judges the frame as a whole.
    logic [7:0] q[$];
    logic [7:0] m_pay [MAX_LEN];
    bit         model_ready = 0;
    bit         in_frame    = 0;
    bit         holding     = 0;
    int         idle        = 0;
    bit         exp_valid   = 0;
    bit         exp_ferr    = 0;
    bit         exp_ovr     = 0;
    bit         exp_pay_ok  = 0;
    int         exp_code    = 0;
    int         exp_op      = 0;
    int         exp_len     = 0;
    int         exp_pay     = 0;

    task automatic m_abort(input int code);
        in_frame = 0;
        exp_ferr = 1;
        exp_code = code;
    endtask

    always @(posedge clk) begin
        int n;
        logic [7:0] x;
        exp_ferr = 0;
        exp_ovr  = 0;
        if (rst) begin
            model_ready = 1;
            in_frame    = 0;
            holding     = 0;
            exp_valid   = 0;
            exp_code    = 0;
            exp_pay_ok  = 0;
            idle        = 0;
            q.delete();
        end else begin
            if (holding) begin
                if (rx_valid) exp_ovr = 1;
                if (cmd_ready) begin
                    holding   = 0;
                    exp_valid = 0;
                end
            end else if (!in_frame) begin
                if (rx_valid && !rx_perr && rx_data == 8'hA5) begin
                    in_frame = 1;
                    idle     = 0;
                    q.delete();
                end
            end else if (rx_valid) begin
                idle = 0;
                if (rx_perr) begin
                    m_abort(4);
                end else begin
                    q.push_back(rx_data);
                    n = q.size();
                    if (n == 2 && int'(q[1]) > MAX_LEN) begin
                        m_abort(2);
                    end else if (n >= 2 && n == int'(q[1]) + 3) begin
                        x = 8'h00;
                        for (int i = 0; i < n - 1; i++) x = x ^ q[i];
                        if (x == q[n-1]) begin
                            in_frame  = 0;
                            holding   = 1;
                            exp_valid = 1;
                            exp_op    = int'(q[0]);
                            exp_len   = int'(q[1]);
                            for (int i = 0; i < exp_len; i++) m_pay[i] = q[i+2];
                        end else begin
                            m_abort(1);
                        end
                    end
                end
            end else begin
                idle++;
                if (idle == TIMEOUT) m_abort(3);
            end
            exp_pay_ok = holding && (int'(pay_addr) < exp_len);
            if (exp_pay_ok) exp_pay = int'(m_pay[pay_addr]);
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            check("cmd_valid", 32'(cmd_valid), 32'(exp_valid));
            check("frame_err", 32'(frame_err), 32'(exp_ferr));
            check("err_code",  32'(err_code),  exp_code);
            check("overrun",   32'(overrun),   32'(exp_ovr));
            if (exp_valid) begin
                check("cmd_op",  32'(cmd_op),  exp_op);
                check("cmd_len", 32'(cmd_len), exp_len);
            end
            if (exp_pay_ok) check("pay_data", 32'(pay_data), exp_pay);
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic p = 1'b0);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_perr  = p;
        step(1);
        rx_valid = 1'b0;
        rx_perr  = 1'b0;
    endtask

    task automatic good_frame();
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h65);
    endtask

    task automatic read_pay(input logic [3:0] a, input logic [7:0] exp, input string name);
        pay_addr = a;
        step(1);
        check(name, 32'(pay_data), 32'(exp));
    endtask

    task automatic accept();
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        check("valid_low_after_handshake", 32'(cmd_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        rx_perr   = 1'b0;
        cmd_ready = 1'b0;
        pay_addr  = 4'd0;
        step(3);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_err_code",  32'(err_code),  32'd0);
        check("rst_pay_data",  32'(pay_data),  32'd0);
        rst = 1'b0;
        step(2);

        // Good frame
        good_frame();
        check("good_valid", 32'(cmd_valid), 32'd1);
        check("good_op",    32'(cmd_op),    32'h10);
        check("good_len",   32'(cmd_len),   32'd2);
        check("model_op",   exp_op,         32'h10);
        read_pay(4'd0, 8'h33, "good_pay0");
        read_pay(4'd1, 8'h44, "good_pay1");
        accept();
        step(2);

        // Bad checksum, then a good frame
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h66);
        check("chk_ferr", 32'(frame_err), 32'd1);
        check("chk_code", 32'(err_code),  32'd1);
        check("chk_valid", 32'(cmd_valid), 32'd0);
        step(1);
        good_frame();
        check("after_bad_valid", 32'(cmd_valid), 32'd1);
        accept();
        step(1);

        // Bad length, then zero-length frame
        send(8'hA5); send(8'h20); send(8'h11);
        check("len_ferr", 32'(frame_err), 32'd1);
        check("len_code", 32'(err_code),  32'd2);
        step(1);
        send(8'hA5); send(8'h07); send(8'h00); send(8'h07);
        check("zero_valid", 32'(cmd_valid), 32'd1);
        check("zero_len",   32'(cmd_len),   32'd0);
        check("zero_op",    32'(cmd_op),    32'h07);
        accept();
        step(1);

        // Timeout: 100 idle cycles abort
        send(8'hA5); send(8'h10);
        step(TIMEOUT - 1);
        check("to_not_yet", 32'(frame_err), 32'd0);
        step(1);
        check("to_ferr", 32'(frame_err), 32'd1);
        check("to_code", 32'(err_code),  32'd3);
        step(1);

        // Byte on the limit cycle wins
        send(8'hA5); send(8'h10);
        step(TIMEOUT - 1);
        send(8'h02);
        check("limit_no_ferr", 32'(frame_err), 32'd0);
        send(8'h33); send(8'h44); send(8'h65);
        check("limit_valid", 32'(cmd_valid), 32'd1);
        accept();
        step(1);

        // Noise and parity
        send(8'h00); send(8'hFF); send(8'hA5, 1'b1);
        send(8'h10); send(8'h02);
        check("noise_ferr",  32'(frame_err), 32'd0);
        check("noise_valid", 32'(cmd_valid), 32'd0);
        step(TIMEOUT + 5);
        check("noise_no_timeout", 32'(err_code), 32'd3);
        send(8'hA5); send(8'h10, 1'b1);
        check("par_ferr", 32'(frame_err), 32'd1);
        check("par_code", 32'(err_code),  32'd4);
        step(1);

        // Hold and overrun
        good_frame();
        send(8'h55);
        check("ovr_pulse", 32'(overrun),   32'd1);
        check("ovr_op",    32'(cmd_op),    32'h10);
        check("ovr_valid", 32'(cmd_valid), 32'd1);
        step(1);
        check("ovr_once", 32'(overrun), 32'd0);
        read_pay(4'd0, 8'h33, "ovr_pay0");
        read_pay(4'd1, 8'h44, "ovr_pay1");
        accept();
        step(1);

        // Reset during payload
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33);
        rst = 1'b1;
        step(1);
        check("mid_rst_ferr",  32'(frame_err), 32'd0);
        check("mid_rst_code",  32'(err_code),  32'd0);
        check("mid_rst_op",    32'(cmd_op),    32'd0);
        check("mid_rst_len",   32'(cmd_len),   32'd0);
        check("mid_rst_pay",   32'(pay_data),  32'd0);
        check("mid_rst_valid", 32'(cmd_valid), 32'd0);
        rst = 1'b0;
        send(8'h44); send(8'h65);
        step(3);
        check("post_rst_idle", 32'(cmd_valid), 32'd0);
        good_frame();
        check("post_rst_good", 32'(cmd_valid), 32'd1);
        accept();
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
